// File: rtl/sme_param_matcher_if.sv
// Byte-serial load bus and result port of the string-matching engine.
interface sme_param_matcher_if #(
    parameter int unsigned CHAR_W = 8,
    parameter int unsigned IDX_W  = 5
) ();
    logic [CHAR_W-1:0] chardata;
    logic              isstring;
    logic              ispattern;
    logic              case_ins;
    logic              valid;
    logic              match;
    logic [IDX_W-1:0]  match_index;

    modport master (
        output chardata, isstring, ispattern, case_ins,
        input  valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern, case_ins,
        output valid, match, match_index
    );
endinterface

// File: rtl/sme_param_matcher.sv
// Loads a string and an anchored/wildcard pattern byte-serially, then scans for the first
// occurrence one body character per cycle and reports it in a one-cycle DONE state.
module sme_param_matcher #(
    parameter int unsigned       CHAR_W   = 8,
    parameter int unsigned       STR_MAX  = 32,
    parameter int unsigned       PAT_MAX  = 8,
    parameter int unsigned       IDX_W    = 5,
    parameter logic [CHAR_W-1:0] ANY_CHAR = 'h2E,
    parameter logic [CHAR_W-1:0] BOL_CHAR = 'h5E,
    parameter logic [CHAR_W-1:0] EOL_CHAR = 'h24,
    parameter logic [CHAR_W-1:0] SEP_CHAR = 'h20
) (
    input logic                clk,
    input logic                reset,
    sme_param_matcher_if.slave bus
);
    localparam int unsigned LEN_W  = $clog2(STR_MAX + 1);
    localparam int unsigned PLEN_W = $clog2(PAT_MAX + 1);
    localparam int unsigned PIDX_W = $clog2(PAT_MAX);
    localparam int unsigned SUM_W  = LEN_W + 1;
    localparam logic [LEN_W-1:0]  SMAX = LEN_W'(STR_MAX);
    localparam logic [PLEN_W-1:0] PMAX = PLEN_W'(PAT_MAX);

    typedef enum logic [2:0] {StIdle, StRecvS, StRecvP, StScan, StDone} state_e;

    state_e             state_q, state_d;
    logic [CHAR_W-1:0]  str_q [STR_MAX];
    logic [CHAR_W-1:0]  pat_q [PAT_MAX];
    logic [LEN_W-1:0]   slen_q, slen_d, s_q, s_d;
    logic [PLEN_W-1:0]  plen_q, plen_d, k_q, k_d;
    logic               str_prev_q, pat_prev_q, first_q, ci_q, ci_d;
    logic               match_q, match_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               load_ok, str_we, pat_we, str_store, pat_store;
    logic [IDX_W-1:0]   str_waddr;
    logic [PIDX_W-1:0]  pat_waddr;
    logic               hat, dol, prev_sep, dol_ok, char_eq;
    logic [PLEN_W-1:0]  blen;
    logic [SUM_W-1:0]   s_end, s_k;
    logic [CHAR_W-1:0]  pc, sc;

    function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
        if (c >= CHAR_W'('h41) && c <= CHAR_W'('h5A)) return c | CHAR_W'('h20);
        return c;
    endfunction

    // A string strobe always wins over a simultaneous pattern strobe.
    always_comb begin
        load_ok   = (state_q == StIdle) || (state_q == StRecvS) || (state_q == StDone);
        str_we    = load_ok && bus.isstring;
        pat_we    = (load_ok || state_q == StRecvP) && bus.ispattern && !bus.isstring;
        str_store = str_we && (!str_prev_q || slen_q < SMAX);
        pat_store = pat_we && (!pat_prev_q || plen_q < PMAX);
        str_waddr = str_prev_q ? slen_q[IDX_W-1:0] : '0;
        pat_waddr = pat_prev_q ? plen_q[PIDX_W-1:0] : '0;
        slen_d    = slen_q;
        plen_d    = plen_q;
        if (str_store) slen_d = str_prev_q ? slen_q + LEN_W'(1) : LEN_W'(1);
        if (pat_store) plen_d = pat_prev_q ? plen_q + PLEN_W'(1) : PLEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (str_store) str_q[str_waddr] <= bus.chardata;
        if (pat_store) pat_q[pat_waddr] <= bus.chardata;
    end

    // Pattern decode and the per-cycle comparison for candidate s_q, body position k_q.
    always_comb begin
        hat      = (plen_q != '0) && (pat_q[0] == BOL_CHAR);
        dol      = (plen_q > PLEN_W'(hat)) &&
                   (pat_q[PIDX_W'(plen_q - PLEN_W'(1))] == EOL_CHAR);
        blen     = plen_q - PLEN_W'(hat) - PLEN_W'(dol);
        s_end    = SUM_W'(s_q) + SUM_W'(blen);
        s_k      = SUM_W'(s_q) + SUM_W'(k_q);
        ci_d     = first_q ? bus.case_ins : ci_q;
        pc       = pat_q[PIDX_W'(k_q + PLEN_W'(hat))];
        sc       = str_q[s_k[IDX_W-1:0]];
        char_eq  = (pc == ANY_CHAR) || (ci_d ? (fold(pc) == fold(sc)) : (pc == sc));
        prev_sep = (s_q == '0) || (str_q[IDX_W'(s_q - LEN_W'(1))] == SEP_CHAR);
        dol_ok   = (s_end == SUM_W'(slen_q)) ||
                   ((s_end < SUM_W'(slen_q)) && (str_q[s_end[IDX_W-1:0]] == SEP_CHAR));
    end

    always_comb begin
        state_d = state_q;
        s_d     = '0;
        k_d     = '0;
        match_d = match_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.isstring)       state_d = StRecvS;
                else if (bus.ispattern) state_d = StRecvP;
                else                    state_d = StIdle;
            end
            StRecvS: if (!bus.isstring)  state_d = StRecvP;
            StRecvP: if (!bus.ispattern) state_d = StScan;
            StScan: begin
                s_d = s_q;
                k_d = k_q;
                if (slen_q == '0 || plen_q == '0 || s_q >= slen_q ||
                    s_end > SUM_W'(slen_q)) begin
                    match_d = 1'b0;
                    idx_d   = '0;
                    state_d = StDone;
                end else if (k_q < blen) begin
                    if (char_eq) begin
                        k_d = k_q + PLEN_W'(1);
                    end else begin
                        s_d = s_q + LEN_W'(1);
                        k_d = '0;
                    end
                end else if ((!hat || prev_sep) && (!dol || dol_ok)) begin
                    match_d = 1'b1;
                    idx_d   = s_q[IDX_W-1:0];
                    state_d = StDone;
                end else begin
                    s_d = s_q + LEN_W'(1);
                    k_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            slen_q     <= '0;
            plen_q     <= '0;
            str_prev_q <= 1'b0;
            pat_prev_q <= 1'b0;
            s_q        <= '0;
            k_q        <= '0;
            first_q    <= 1'b1;
            ci_q       <= 1'b0;
            match_q    <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            slen_q     <= slen_d;
            plen_q     <= plen_d;
            str_prev_q <= str_we;
            pat_prev_q <= pat_we;
            s_q        <= s_d;
            k_q        <= k_d;
            first_q    <= (state_q != StScan);
            ci_q       <= ci_d;
            match_q    <= match_d;
            idx_q      <= idx_d;
        end
    end

    assign bus.valid       = (state_q == StDone);
    assign bus.match       = match_q;
    assign bus.match_index = idx_q;
endmodule

// File: tb/tb_sme_param_matcher.sv
// Directed bench for sme_param_matcher: hand-computed match results, pulse shape, latency, reset.
module tb_sme_param_matcher;
    localparam int LAT_MAX = 1 + 32 * (8 + 1);

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    sme_param_matcher_if #(.CHAR_W(8), .IDX_W(5)) bus ();

    sme_param_matcher dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] c, input logic s, input logic p);
        @(negedge clk);
        bus.chardata  = c;
        bus.isstring  = s;
        bus.ispattern = p;
    endtask

    task automatic quiet();
        @(negedge clk);
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        bus.chardata  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i], 1'b1, 1'b0);
    endtask

    task automatic send_pat(input string p, input logic ci);
        bus.case_ins = ci;
        for (int i = 0; i < p.len(); i++) put(p[i], 1'b0, 1'b1);
        quiet();
    endtask

    // Waits for valid, bounded by the latency limit, then checks result and one-cycle pulse.
    task automatic wait_result(input string tag, input logic exp_m, input int exp_i);
        int  cycles = 0;
        bit  got = 0;
        while (cycles < LAT_MAX + 4 && !got) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.valid) got = 1;
        end
        check_eq({tag, "_valid"}, 32'(got), 1);
        check_eq({tag, "_latency_ok"}, 32'(cycles <= LAT_MAX), 1);
        check_eq({tag, "_match"}, 32'(bus.match), 32'(exp_m));
        check_eq({tag, "_index"}, 32'(bus.match_index), exp_i);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse_once"}, 32'(bus.valid), 0);
    endtask

    task automatic run(input string tag, input string s, input string p, input logic ci,
                       input logic exp_m, input int exp_i);
        if (s.len() > 0) send_str(s);
        send_pat(p, ci);
        wait_result(tag, exp_m, exp_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        string long_s;
        int    pulses;

        reset         = 1'b1;
        bus.chardata  = 8'h00;
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        bus.case_ins  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("reset_valid", 32'(bus.valid), 0);
        check_eq("reset_match", 32'(bus.match), 0);
        check_eq("reset_index", 32'(bus.match_index), 0);

        run("wor", "hello world", "wor", 1'b0, 1'b1, 6);
        run("hat_wor", "", "^wor", 1'b0, 1'b1, 6);
        run("o_dol", "", "o$", 1'b0, 1'b1, 4);
        run("lo_dol", "", "lo$", 1'b0, 1'b1, 3);
        run("wr_none", "", "wr", 1'b0, 1'b0, 0);
        run("d_dol", "", "d$", 1'b0, 1'b1, 10);

        run("any", "abcab", "a.c", 1'b0, 1'b1, 0);
        run("ci_on", "", "ABC", 1'b1, 1'b1, 0);
        run("ci_off", "", "ABC", 1'b0, 1'b0, 0);
        run("ab_dol", "", "ab$", 1'b0, 1'b1, 3);

        long_s = "";
        for (int i = 0; i < 31; i++) long_s = {long_s, "a"};
        for (int i = 0; i < 9; i++) long_s = {long_s, "q"};
        run("sat_q", long_s, "q", 1'b0, 1'b1, 31);
        run("sat_qq", "", "qq", 1'b0, 1'b0, 0);
        run("sat_aq_dol", "", "aq$", 1'b0, 1'b1, 30);

        // The overlapping pattern strobe must be ignored, leaving pattern "b".
        put("a", 1'b1, 1'b0);
        put("b", 1'b1, 1'b1);
        put("b", 1'b0, 1'b1);
        quiet();
        wait_result("overlap", 1'b1, 1);

        for (int i = 0; i < 20; i++) put("a", 1'b1, 1'b0);
        put("a", 1'b0, 1'b1);
        put("b", 1'b0, 1'b1);
        quiet();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midscan_valid", 32'(bus.valid), 0);
        check_eq("midscan_match", 32'(bus.match), 0);
        check_eq("midscan_index", 32'(bus.match_index), 0);
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.valid) pulses++;
        end
        check_eq("midscan_no_valid", 32'(pulses), 0);

        run("empty_str", "", "x", 1'b0, 1'b0, 0);
        run("hat_only", "ab", "^", 1'b0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
